// File: rtl/bip_loader_pkg.sv
// Shared definitions for the BIP program loader: FSM states, HALT word and default widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Optional feature macro: LOADER_CHECKSUM_EN adds the WAIT_CHK state.
package bip_loader_pkg;

  localparam int DEFAULT_ADDRESS_BITS = 11;
  localparam int DEFAULT_DATA_BITS    = 16;
  localparam int DEFAULT_BYTE_BITS    = 8;

  // A program ends with this instruction word; it is still written to memory.
  localparam logic [15:0] HALT_WORD = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_WRITE,
`ifdef LOADER_CHECKSUM_EN
    ST_WAIT_CHK,
`endif
    ST_DONE
  } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Bundle of the loader's byte-stream input and program-memory write/status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; the byte stream is strobe-only and the memory port always accepts.
// Ports: i_start, i_rx_data, i_rx_valid (stream side); o_wr_en, o_wr_address, o_wr_data,
//        o_busy, o_done, o_overflow, and o_checksum_err when LOADER_CHECKSUM_EN is defined.
// master = stimulus/UART side, slave = the loader itself.
interface program_loader_if
  import bip_loader_pkg::*;
#(
  parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int BYTE_BITS    = DEFAULT_BYTE_BITS
);

  logic                    i_start;
  logic [BYTE_BITS-1:0]    i_rx_data;
  logic                    i_rx_valid;
  logic                    o_wr_en;
  logic [ADDRESS_BITS-1:0] o_wr_address;
  logic [DATA_BITS-1:0]    o_wr_data;
  logic                    o_busy;
  logic                    o_done;
  logic                    o_overflow;
`ifdef LOADER_CHECKSUM_EN
  logic                    o_checksum_err;
`endif

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_wr_en, o_wr_address, o_wr_data, o_busy, o_done, o_overflow
`ifdef LOADER_CHECKSUM_EN
    , input o_checksum_err
`endif
  );

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_wr_en, o_wr_address, o_wr_data, o_busy, o_done, o_overflow
`ifdef LOADER_CHECKSUM_EN
    , output o_checksum_err
`endif
  );

endinterface

// File: rtl/loader_checksum.sv
// XOR accumulator over the program bytes of one load, compared against a trailing checksum byte.
// Latency: accumulate in 1 cycle; mismatch is combinational from the current accumulator.
// Backpressure: none; clear wins over enable.
// Ports: clk, rst (async active-low), clear, enable, data, mismatch.
// Only built when LOADER_CHECKSUM_EN is defined.
`ifdef LOADER_CHECKSUM_EN
module loader_checksum
  import bip_loader_pkg::*;
#(
  parameter int BYTE_BITS = DEFAULT_BYTE_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [BYTE_BITS-1:0] data,
  output logic                 mismatch
);

  logic [BYTE_BITS-1:0] acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc ^ data;
    end
  end

  assign mismatch = (acc != data);

endmodule
`endif

// File: rtl/program_loader.sv
// Loads a BIP program from a byte stream into program memory, high byte first, until HALT or memory full.
// Latency: write pulse 1 cycle after the low byte is sampled; o_busy 1 cycle after i_start.
// Backpressure: none; a byte may arrive every cycle (one in the WRITE cycle becomes the next high byte).
// Ports: clk, rst (async active-low), bus (program_loader_if.slave).
// Optional: LOADER_CHECKSUM_EN appends a checksum byte check and o_checksum_err.
module program_loader
  import bip_loader_pkg::*;
#(
  parameter int ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int BYTE_BITS    = DEFAULT_BYTE_BITS
) (
  input  logic            clk,
  input  logic            rst,
  program_loader_if.slave bus
);

  state_t                  state;
  logic [ADDRESS_BITS-1:0] counter;
  logic [BYTE_BITS-1:0]    hi_byte;
  logic [DATA_BITS-1:0]    word;
  logic                    wr_en_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    overflow_q;
  logic                    last_word;

  // The word in flight ends the load if it is HALT or sits in the last address.
  assign last_word = (word == DATA_BITS'(HALT_WORD)) || (counter == {ADDRESS_BITS{1'b1}});

  // The counter and word registers double as the write address/data outputs;
  // they only matter while o_wr_en is high.
  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_address = counter;
  assign bus.o_wr_data    = word;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_overflow   = overflow_q;

`ifdef LOADER_CHECKSUM_EN
  logic sum_en;
  logic sum_mismatch;
  logic chk_err_q;

  // Every byte that becomes part of a word is folded in; restart bytes and
  // bytes after the terminating write are not.
  assign sum_en = bus.i_rx_valid && !bus.i_start &&
                  ((state == ST_WAIT_HI) || (state == ST_WAIT_LO) ||
                   ((state == ST_WRITE) && !last_word));

  loader_checksum #(.BYTE_BITS(BYTE_BITS)) u_checksum (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.i_start),
    .enable   (sum_en),
    .data     (bus.i_rx_data),
    .mismatch (sum_mismatch)
  );

  assign bus.o_checksum_err = chk_err_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      counter    <= '0;
      hi_byte    <= '0;
      word       <= '0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      chk_err_q  <= 1'b0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      if (bus.i_start) begin
        // Start has priority in every state: partial words and a write that
        // would have followed this cycle's low byte are dropped.
        state      <= ST_WAIT_HI;
        counter    <= '0;
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        overflow_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_err_q  <= 1'b0;
`endif
      end else begin
        case (state)
          ST_WAIT_HI: begin
            if (bus.i_rx_valid) begin
              hi_byte <= bus.i_rx_data;
              state   <= ST_WAIT_LO;
            end
          end
          ST_WAIT_LO: begin
            if (bus.i_rx_valid) begin
              word    <= {hi_byte, bus.i_rx_data};
              wr_en_q <= 1'b1;
              state   <= ST_WRITE;
            end
          end
          ST_WRITE: begin
            if (last_word) begin
              overflow_q <= (word != DATA_BITS'(HALT_WORD));
`ifdef LOADER_CHECKSUM_EN
              state      <= ST_WAIT_CHK;
`else
              state      <= ST_DONE;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
`endif
            end else begin
              counter <= counter + 1'b1;
              if (bus.i_rx_valid) begin
                hi_byte <= bus.i_rx_data;
                state   <= ST_WAIT_LO;
              end else begin
                state   <= ST_WAIT_HI;
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          ST_WAIT_CHK: begin
            if (bus.i_rx_valid) begin
              chk_err_q <= sum_mismatch;
              state     <= ST_DONE;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
            end
          end
`endif
          default: begin
            // IDLE and DONE only leave on i_start; stray bytes are ignored.
          end
        endcase
      end
    end
  end

endmodule
